// File: rtl/alu_multicycle_seq.sv
`default_nettype none
// ============================================================================
// Module : alu_multicycle_seq
// Brief  : Stall/sequencing control for the iterative VDIV/VMOD/VSQRT unit.
// Rev    : 1.0  initial release
// ============================================================================

module alu_multicycle_seq #(
    parameter int DIV_BASE  = 2,
    parameter int SQRT_BASE = 2,
    parameter int CNT_W     = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [0:31] ID_EX_Instr,
    input  logic        ID_EX_Valid,
    input  logic [0:63] rB_data,
    input  logic        ex_flush,
    output logic        EX_Stall,
    output logic        mc_start,
    output logic [1:0]  mc_op,
    output logic [1:0]  mc_ww,
    output logic        mc_busy,
    output logic        mc_done,
    output logic [0:7]  mc_div0
);

    localparam logic [5:0] C_TYPE_VEC  = 6'b101010;
    localparam logic [5:0] C_OPC_VDIV  = 6'b001110;
    localparam logic [5:0] C_OPC_VMOD  = 6'b001111;
    localparam logic [5:0] C_OPC_VSQRT = 6'b010010;
    localparam logic [1:0] C_OP_DIV    = 2'b00;
    localparam logic [1:0] C_OP_MOD    = 2'b01;
    localparam logic [1:0] C_OP_SQRT   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [1:0]         ww_q, ww_d;
    logic [0:7]         div0_q, div0_d;
    logic               start_q, start_d;

    logic [5:0]         instr_type;
    logic [1:0]         instr_ww;
    logic [5:0]         instr_opc;
    logic               opc_hit;
    logic [1:0]         op_dec;
    logic               accept;
    logic [CNT_W-1:0]   lat_m1;
    logic [0:7]         zero_det;
    logic               w_unused;

    assign instr_type = ID_EX_Instr[0:5];
    assign instr_ww   = ID_EX_Instr[24:25];
    assign instr_opc  = ID_EX_Instr[26:31];
    assign w_unused   = ^ID_EX_Instr[6:23];

    always_comb begin
        opc_hit = 1'b1;
        op_dec  = C_OP_DIV;
        case (instr_opc)
            C_OPC_VDIV:  op_dec = C_OP_DIV;
            C_OPC_VMOD:  op_dec = C_OP_MOD;
            C_OPC_VSQRT: op_dec = C_OP_SQRT;
            default:     opc_hit = 1'b0;
        endcase
    end

    // Reset is folded in so the combinational stall is also quiet during reset.
    assign accept = reset_n && (state_q == ST_IDLE) && ID_EX_Valid &&
                    (instr_type == C_TYPE_VEC) && opc_hit && !ex_flush;

    // Counter load value is N-1: div uses L/4 = 2<<WW, sqrt uses L/8 = 1<<WW.
    always_comb begin
        if (op_dec == C_OP_SQRT)
            lat_m1 = CNT_W'((32'd1 << instr_ww) + 32'(SQRT_BASE) - 32'd1);
        else
            lat_m1 = CNT_W'((32'd2 << instr_ww) + 32'(DIV_BASE) - 32'd1);
    end

    // Lane k occupies rB_data[k*L : k*L+L-1]; lanes beyond 64/L stay clear.
    always_comb begin
        zero_det = '0;
        case (instr_ww)
            2'b00: for (int k = 0; k < 8; k++) zero_det[k] = (rB_data[k*8 +: 8] == 8'd0);
            2'b01: for (int k = 0; k < 4; k++) zero_det[k] = (rB_data[k*16 +: 16] == 16'd0);
            2'b10: for (int k = 0; k < 2; k++) zero_det[k] = (rB_data[k*32 +: 32] == 32'd0);
            default: zero_det[0] = (rB_data == 64'd0);
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        ww_d    = ww_q;
        div0_d  = div0_q;
        start_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_BUSY;
                    cnt_d   = lat_m1;
                    op_d    = op_dec;
                    ww_d    = instr_ww;
                    div0_d  = (op_dec == C_OP_SQRT) ? 8'd0 : zero_det;
                    start_d = 1'b1;
                end
            end
            ST_BUSY: begin
                if (ex_flush)
                    state_d = ST_IDLE;
                else if (cnt_q == '0)
                    state_d = ST_DONE;
                else
                    cnt_d = cnt_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            ww_q    <= '0;
            div0_q  <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            ww_q    <= ww_d;
            div0_q  <= div0_d;
            start_q <= start_d;
        end
    end

    // A flush landing in DONE suppresses the completion pulse.
    assign EX_Stall = accept || (state_q == ST_BUSY);
    assign mc_start = start_q;
    assign mc_op    = op_q;
    assign mc_ww    = ww_q;
    assign mc_div0  = div0_q;
    assign mc_busy  = (state_q != ST_IDLE);
    assign mc_done  = (state_q == ST_DONE) && !ex_flush;

endmodule

`default_nettype wire

// File: tb/tb_alu_multicycle_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_multicycle_seq
// Brief  : Directed self-checking bench for the multi-cycle ALU sequencer.
// Rev    : 1.0  initial release
// ============================================================================

module tb_alu_multicycle_seq;

    logic        clk;
    logic        reset_n;
    logic [0:31] instr;
    logic        valid;
    logic [0:63] rb;
    logic        flush;
    logic        stall;
    logic        start;
    logic [1:0]  op;
    logic [1:0]  ww;
    logic        busy;
    logic        done;
    logic [0:7]  div0;

    int n_total = 0;
    int n_bad   = 0;

    alu_multicycle_seq #(
        .DIV_BASE  (2),
        .SQRT_BASE (2),
        .CNT_W     (5)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ID_EX_Instr (instr),
        .ID_EX_Valid (valid),
        .rB_data     (rb),
        .ex_flush    (flush),
        .EX_Stall    (stall),
        .mc_start    (start),
        .mc_op       (op),
        .mc_ww       (ww),
        .mc_busy     (busy),
        .mc_done     (done),
        .mc_div0     (div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [0:31] mk(input logic [5:0] t, input logic [1:0] w, input logic [5:0] o);
        logic [0:31] r;
        r        = '0;
        r[0:5]   = t;
        r[24:25] = w;
        r[26:31] = o;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one op at cycle T and checks every cycle through DONE; drops
    // valid in the DONE cycle so it is not re-accepted.
    task automatic run_op(input string tag, input logic [5:0] opc, input logic [1:0] w,
                          input logic [0:63] rbv, input int n, input logic [1:0] eop,
                          input logic [7:0] ediv0);
        instr = mk(6'b101010, w, opc);
        valid = 1'b1;
        rb    = rbv;
        for (int c = 0; c <= n + 1; c++) begin
            if (c == n + 1) valid = 1'b0;
            #1;
            chk({tag, "_stall"}, stall, (c <= n));
            chk({tag, "_start"}, start, (c == 1));
            chk({tag, "_done"},  done,  (c == n + 1));
            chk({tag, "_busy"},  busy,  (c >= 1));
            if (c == 1) begin
                chk({tag, "_op"},   op,   eop);
                chk({tag, "_ww"},   ww,   w);
                chk({tag, "_div0"}, div0, ediv0);
            end
            tick();
        end
        #1;
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int nd;
        reset_n = 1'b0;
        instr   = '0;
        valid   = 1'b0;
        rb      = '0;
        flush   = 1'b0;
        tick();
        tick();
        chk("rst_stall", stall, 0);
        chk("rst_start", start, 0);
        chk("rst_busy",  busy,  0);
        chk("rst_done",  done,  0);
        chk("rst_outs",  {op, ww, div0}, 0);
        reset_n = 1'b1;
        tick();

        // Reset mid-BUSY: VMOD W64, divisor zero
        instr = mk(6'b101010, 2'b11, 6'b001111);
        valid = 1'b1;
        rb    = 64'd0;
        tick();
        tick();
        tick();
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_outs", {op, ww, div0}, {2'b01, 2'b11, 8'h80});
        reset_n = 1'b0;
        valid   = 1'b0;
        tick();
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_busy",  busy,  0);
        chk("mid_rst_done",  done,  0);
        chk("mid_rst_start", start, 0);
        chk("mid_rst_outs",  {op, ww, div0}, 0);
        tick();
        reset_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 25; i++) begin
            if (done || busy) nd++;
            tick();
        end
        chk("mid_rst_no_done", nd, 0);

        run_op("vdiv_w8",  6'b001110, 2'b00, 64'h0101_0101_0101_0101, 4, 2'b00, 8'h00);
        run_op("vmod_w32", 6'b001111, 2'b10, {32'd5, 32'd0}, 10, 2'b01, 8'b0100_0000);
        run_op("vdiv_w8z", 6'b001110, 2'b00, 64'h00FF_0000_1100_0001, 4, 2'b00, 8'b1011_0110);
        run_op("vsqrt_w8", 6'b010010, 2'b00, 64'd0, 3, 2'b10, 8'h00);
        run_op("vdiv_w64", 6'b001110, 2'b11, 64'd7, 18, 2'b00, 8'h00);
        chk("hold_outs", {op, ww, div0}, {2'b00, 2'b11, 8'h00});

        // VSQRT W64 flushed at T+3
        instr = mk(6'b101010, 2'b11, 6'b010010);
        valid = 1'b1;
        rb    = 64'd1;
        #1;
        chk("fl_stall_t0", stall, 1);
        tick();
        tick();
        tick();
        flush = 1'b1;
        #1;
        chk("fl_stall_t3", stall, 1);
        chk("fl_busy_t3",  busy,  1);
        tick();
        flush = 1'b0;
        valid = 1'b0;
        #1;
        chk("fl_stall_t4", stall, 0);
        chk("fl_busy_t4",  busy,  0);
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) nd++;
            tick();
        end
        chk("fl_no_done", nd, 0);

        // Non multi-cycle instructions and flush in IDLE are ignored
        instr = mk(6'b101010, 2'b00, 6'b000110);
        valid = 1'b1;
        #1;
        chk("vadd_stall", stall, 0);
        tick();
        chk("vadd_start", start, 0);
        chk("vadd_busy",  busy,  0);
        instr = mk(6'b100000, 2'b00, 6'b001110);
        #1;
        chk("load_stall", stall, 0);
        tick();
        chk("load_start", start, 0);
        chk("load_busy",  busy,  0);
        instr = mk(6'b101010, 2'b00, 6'b001110);
        flush = 1'b1;
        #1;
        chk("idle_fl_stall", stall, 0);
        tick();
        chk("idle_fl_start", start, 0);
        chk("idle_fl_busy",  busy,  0);
        flush = 1'b0;
        valid = 1'b0;
        tick();

        // Back-to-back: VDIV W16 (N=6) then VSQRT W16 (N=4) at T+8
        run_op("b2b_vdiv",  6'b001110, 2'b01, 64'h0001_0002_0003_0000, 6, 2'b00, 8'b0001_0000);
        run_op("b2b_vsqrt", 6'b010010, 2'b01, 64'd0, 4, 2'b10, 8'h00);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
